// File: rtl/sw_ctrl_pkg.sv
// rtl/sw_ctrl_pkg.sv - shared register map and limits for the switch debounce controller
package sw_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int DB_TICKS_MIN = 1;
  localparam int DB_TICKS_MAX = 15;

  // 1 ms debounce tick at a 50 MHz system clock
  localparam int PRESCALE_RST_DEFAULT = 50000;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - per-switch synchronizer, stability counter and accepted level
module sw_debounce_bit
  import sw_ctrl_pkg::*;
#(
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam logic [3:0] LAST_COUNT = 4'(DB_TICKS - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      count  <= 4'd0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle where the input agrees with the accepted level abandons the run
      if (sync2 == stable) begin
        count <= 4'd0;
      end else if (tick) begin
        if (count == LAST_COUNT) begin
          stable <= ~stable;
          count  <= 4'd0;
        end else begin
          count <= count + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce_irq_ctrl.sv
// rtl/sw_debounce_irq_ctrl.sv - debounced switch port with edge capture, irq mask and Avalon-MM registers
module sw_debounce_irq_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DB_TICKS     = 4,
  parameter int PRESCALE_RST = PRESCALE_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [15:0]      debounce_q;
  logic [15:0]      presc_cnt;
  logic [15:0]      presc_last;
  logic             tick;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] w1c_vec;
  logic [31:0]      rd_mux;
  logic             wr_mask;
  logic             wr_debounce;
  logic             wr_edge;

  assign wr_mask     = write && (address == ADDR_IRQ_MASK);
  assign wr_debounce = write && (address == ADDR_DEBOUNCE);
  assign wr_edge     = write && (address == ADDR_EDGE_CAP);

  // A reload of 0 is treated as 1 so the tick then fires every cycle
  assign presc_last = (debounce_q == 16'd0) ? 16'd0 : debounce_q - 16'd1;
  assign tick       = (presc_cnt >= presc_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= 16'd0;
    end else if (wr_debounce || tick) begin
      presc_cnt <= 16'd0;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(.DB_TICKS(DB_TICKS)) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .raw    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign edge_vec = stable ^ stable_q;
  assign w1c_vec  = wr_edge ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounce_q <= 16'(PRESCALE_RST);
      irq_mask   <= '0;
      edge_cap   <= '0;
      stable_q   <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_debounce) debounce_q <= writedata[15:0];
      if (wr_mask)     irq_mask   <= writedata[WIDTH-1:0];
      stable_q <= stable;
      // New edges override a same-cycle clear
      edge_cap <= (edge_cap & ~w1c_vec) | edge_vec;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_DEBOUNCE: rd_mux[15:0]      = debounce_q;
      default:       rd_mux[WIDTH-1:0] = edge_cap;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

endmodule
